// File: rtl/mcp9808_scheduler_pkg.sv
// Shared encodings for the MCP9808 scheduler: FSM states, request kinds and
// boundary-register select codes as the sensor interface block defines them.
package mcp9808_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GUARD = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REQ_SD  = 2'd0,
        REQ_BND = 2'd1,
        REQ_RES = 2'd2,
        REQ_RD  = 2'd3
    } req_e;

    typedef enum logic [1:0] {
        BND_NONE  = 2'b00,
        BND_LOWER = 2'b01,
        BND_UPPER = 2'b10,
        BND_CRIT  = 2'b11
    } bnd_sel_e;

    function automatic logic [15:0] pack_sample(input logic [2:0]  tcomp,
                                                input logic        tsign,
                                                input logic [11:0] tval);
        return {tcomp, tsign, tval};
    endfunction

endpackage

// File: rtl/mcp9808_scheduler_if.sv
// Command/status bus between the scheduler (master) and the MCP9808
// interface block (slave).
interface mcp9808_scheduler_if;
    logic        s_ready;
    logic [11:0] s_tval;
    logic        s_tsign;
    logic [2:0]  s_tcomp;
    logic        s_update;
    logic [1:0]  s_twrite;
    logic [10:0] s_tin;
    logic [1:0]  s_res;
    logic        s_shdn;

    modport master (
        input  s_ready, s_tval, s_tsign, s_tcomp,
        output s_update, s_twrite, s_tin, s_res, s_shdn
    );

    modport slave (
        output s_ready, s_tval, s_tsign, s_tcomp,
        input  s_update, s_twrite, s_tin, s_res, s_shdn
    );
endinterface

// File: rtl/mcp9808_poll_timer.sv
// Periodic read timer: free-runs while enabled and raises a coalesced pending
// flag on each wrap or on an immediate-read pulse; the flag clears at grant.
module mcp9808_poll_timer #(
    parameter logic [23:0] POLL_DIV = 24'd10_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic poll_en_i,
    input  logic rd_now_i,
    input  logic grant_i,
    output logic pend_o
);
    logic [23:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        wrap;

    always_comb begin
        wrap = poll_en_i && (cnt_q >= POLL_DIV - 24'd1);
        if (!poll_en_i || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
        // A new request arriving in the grant cycle survives the clear.
        pend_d = (pend_q && !grant_i) || wrap || rd_now_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
endmodule

// File: rtl/mcp9808_scheduler.sv
// Fixed-priority sequencer for the MCP9808 interface block: one outstanding
// command at a time, with start/done watchdogs and a ready-stable guard window.
module mcp9808_scheduler
    import mcp9808_pkg::*;
#(
    parameter logic [23:0] POLL_DIV = 24'd10_000_000,
    parameter logic [15:0] START_TO = 16'd4096,
    parameter logic [19:0] DONE_TO  = 20'd500_000,
    parameter logic [3:0]  GUARD    = 4'd8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                poll_en_i,
    input  logic                rd_now_i,
    input  logic                bnd_req_i,
    input  logic [1:0]          bnd_sel_i,
    input  logic [10:0]         bnd_val_i,
    output logic                bnd_ack_o,
    input  logic [1:0]          res_cfg_i,
    input  logic                sd_cfg_i,
    mcp9808_scheduler_if.master sns,
    output logic [15:0]         sample_o,
    output logic                sample_vld_o,
    output logic [2:0]          alarm_o,
    input  logic                alarm_clr_i,
    output logic                timeout_err_o,
    output logic                in_shdn_o
);
    state_e      state_q;
    req_e        kind_q;
    logic [15:0] start_cnt_q;
    logic [19:0] done_cnt_q;
    logic [3:0]  guard_cnt_q;
    logic        upd_q;
    logic [1:0]  twrite_q;
    logic [10:0] tin_q;
    logic [1:0]  res_q;
    logic        shdn_q;
    logic [15:0] sample_q;
    logic        vld_q;
    logic [2:0]  alarm_q;
    logic        terr_q;
    logic        ack_q;
    logic        in_shdn_q;

    logic        poll_pend;
    logic        sd_want, bnd_want, res_want, rd_want;
    logic        grant, grant_rd;
    req_e        req_kind;
    logic [2:0]  alarm_keep;

    mcp9808_poll_timer #(
        .POLL_DIV (POLL_DIV)
    ) u_poll (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .poll_en_i (poll_en_i),
        .rd_now_i  (rd_now_i),
        .grant_i   (grant_rd),
        .pend_o    (poll_pend)
    );

    always_comb begin
        sd_want  = (sd_cfg_i != shdn_q);
        bnd_want = bnd_req_i && (bnd_sel_i != BND_NONE);
        res_want = (res_cfg_i != res_q);
        rd_want  = poll_pend && !in_shdn_q;
        if (sd_want) begin
            req_kind = REQ_SD;
        end else if (bnd_want) begin
            req_kind = REQ_BND;
        end else if (res_want) begin
            req_kind = REQ_RES;
        end else begin
            req_kind = REQ_RD;
        end
        grant      = (state_q == ST_IDLE) && sns.s_ready &&
                     (sd_want || bnd_want || res_want || rd_want);
        grant_rd   = grant && (req_kind == REQ_RD);
        alarm_keep = alarm_clr_i ? 3'b000 : alarm_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_GUARD;
            kind_q      <= REQ_RD;
            start_cnt_q <= '0;
            done_cnt_q  <= '0;
            guard_cnt_q <= '0;
            upd_q       <= 1'b0;
            twrite_q    <= '0;
            tin_q       <= '0;
            res_q       <= 2'b11;
            shdn_q      <= 1'b0;
            sample_q    <= '0;
            vld_q       <= 1'b0;
            alarm_q     <= '0;
            terr_q      <= 1'b0;
            ack_q       <= 1'b0;
            in_shdn_q   <= 1'b0;
        end else begin
            vld_q   <= 1'b0;
            ack_q   <= 1'b0;
            alarm_q <= alarm_keep;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        kind_q      <= req_kind;
                        start_cnt_q <= '0;
                        state_q     <= ST_ISSUE;
                        case (req_kind)
                            REQ_SD:  shdn_q <= sd_cfg_i;
                            REQ_BND: begin
                                twrite_q <= bnd_sel_i;
                                tin_q    <= bnd_val_i;
                            end
                            REQ_RES: res_q <= res_cfg_i;
                            REQ_RD:  upd_q <= 1'b1;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (!sns.s_ready) begin
                        done_cnt_q <= '0;
                        state_q    <= ST_BUSY;
                    end else if (start_cnt_q >= START_TO - 16'd1) begin
                        terr_q      <= 1'b1;
                        upd_q       <= 1'b0;
                        twrite_q    <= '0;
                        ack_q       <= (kind_q == REQ_BND);
                        guard_cnt_q <= '0;
                        state_q     <= ST_GUARD;
                    end else begin
                        start_cnt_q <= start_cnt_q + 16'd1;
                    end
                end
                ST_BUSY: begin
                    if (sns.s_ready) begin
                        upd_q       <= 1'b0;
                        twrite_q    <= '0;
                        guard_cnt_q <= '0;
                        state_q     <= ST_GUARD;
                        case (kind_q)
                            REQ_RD: begin
                                sample_q <= pack_sample(sns.s_tcomp, sns.s_tsign, sns.s_tval);
                                vld_q    <= 1'b1;
                                alarm_q  <= alarm_keep | sns.s_tcomp;
                            end
                            REQ_BND: ack_q     <= 1'b1;
                            REQ_SD:  in_shdn_q <= shdn_q;
                            default: ;
                        endcase
                    end else if (done_cnt_q >= DONE_TO - 20'd1) begin
                        // Acknowledge aborted boundary writes so the host never stalls.
                        terr_q      <= 1'b1;
                        upd_q       <= 1'b0;
                        twrite_q    <= '0;
                        ack_q       <= (kind_q == REQ_BND);
                        guard_cnt_q <= '0;
                        state_q     <= ST_GUARD;
                    end else begin
                        done_cnt_q <= done_cnt_q + 20'd1;
                    end
                end
                ST_GUARD: begin
                    if (!sns.s_ready) begin
                        guard_cnt_q <= '0;
                    end else if (guard_cnt_q >= GUARD - 4'd1) begin
                        guard_cnt_q <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        guard_cnt_q <= guard_cnt_q + 4'd1;
                    end
                end
                default: state_q <= ST_GUARD;
            endcase
        end
    end

    assign sns.s_update  = upd_q;
    assign sns.s_twrite  = twrite_q;
    assign sns.s_tin     = tin_q;
    assign sns.s_res     = res_q;
    assign sns.s_shdn    = shdn_q;
    assign bnd_ack_o     = ack_q;
    assign sample_o      = sample_q;
    assign sample_vld_o  = vld_q;
    assign alarm_o       = alarm_q;
    assign timeout_err_o = terr_q;
    assign in_shdn_o     = in_shdn_q;
endmodule

// File: tb/tb_mcp9808_scheduler.sv
// Directed bench for mcp9808_scheduler with a behavioural sensor that drops
// ready for a fixed busy window after each new command.
module tb_mcp9808_scheduler;
    localparam int BUSY_LEN = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        poll_en = 1'b0;
    logic        rd_now = 1'b0;
    logic        bnd_req = 1'b0;
    logic [1:0]  bnd_sel = 2'b00;
    logic [10:0] bnd_val = '0;
    logic        bnd_ack;
    logic [1:0]  res_cfg = 2'b11;
    logic        sd_cfg = 1'b0;
    logic [15:0] sample;
    logic        sample_vld;
    logic [2:0]  alarm;
    logic        alarm_clr = 1'b0;
    logic        timeout_err;
    logic        in_shdn;

    mcp9808_scheduler_if sif();

    mcp9808_scheduler #(
        .POLL_DIV (24'd100),
        .START_TO (16'd32),
        .DONE_TO  (20'd200),
        .GUARD    (4'd8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .poll_en_i     (poll_en),
        .rd_now_i      (rd_now),
        .bnd_req_i     (bnd_req),
        .bnd_sel_i     (bnd_sel),
        .bnd_val_i     (bnd_val),
        .bnd_ack_o     (bnd_ack),
        .res_cfg_i     (res_cfg),
        .sd_cfg_i      (sd_cfg),
        .sns           (sif.master),
        .sample_o      (sample),
        .sample_vld_o  (sample_vld),
        .alarm_o       (alarm),
        .alarm_clr_i   (alarm_clr),
        .timeout_err_o (timeout_err),
        .in_shdn_o     (in_shdn)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int upd_cnt = 0;
    int ack_cnt = 0;
    int trig = 0;
    logic upd_prev = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        upd_prev <= sif.s_update;
        if (sif.s_update && !upd_prev) upd_cnt <= upd_cnt + 1;
        if (bnd_ack) ack_cnt <= ack_cnt + 1;
    end

    // Sensor model
    logic       stuck = 1'b0;
    logic       seen;
    int         bcnt;
    logic [1:0] last_res;
    logic       last_shdn;
    logic       cmd;

    assign cmd = sif.s_update | (sif.s_twrite != 2'b00) |
                 (sif.s_res != last_res) | (sif.s_shdn != last_shdn);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sif.s_ready <= 1'b1;
            bcnt        <= 0;
            seen        <= 1'b0;
            last_res    <= 2'b11;
            last_shdn   <= 1'b0;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) sif.s_ready <= 1'b1;
        end else if (cmd && !seen && !stuck) begin
            sif.s_ready <= 1'b0;
            bcnt        <= BUSY_LEN;
            seen        <= 1'b1;
            last_res    <= sif.s_res;
            last_shdn   <= sif.s_shdn;
            trig        <= trig + 1;
        end else if (!cmd) begin
            seen <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0:       return sif.s_update;
            1:       return sample_vld;
            2:       return bnd_ack;
            3:       return timeout_err;
            4:       return in_shdn;
            5:       return !in_shdn;
            6:       return sif.s_res == 2'b01;
            7:       return !sif.s_ready;
            8:       return sif.s_twrite != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_rise(input int sel, input int budget, input string tag, output int at);
        logic prev, now, found;
        prev  = cond(sel);
        found = 1'b0;
        at    = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            now = cond(sel);
            if (now && !prev) begin
                found = 1'b1;
                at    = cyc;
            end
            prev = now;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic pulse_rd();
        rd_now = 1'b1;
        @(negedge clk);
        rd_now = 1'b0;
    endtask

    int c1, c2, a, u, g, t, v, t0, u0, a0;

    initial begin
        sif.s_tval  = 12'h190;
        sif.s_tsign = 1'b0;
        sif.s_tcomp = 3'b010;

        repeat (3) @(negedge clk);
        check("rst_s_res", {30'd0, sif.s_res}, 32'h3);
        check("rst_s_update", {31'd0, sif.s_update}, 32'h0);
        check("rst_s_twrite", {30'd0, sif.s_twrite}, 32'h0);
        check("rst_sample", {16'd0, sample}, 32'h0);
        check("rst_alarm", {29'd0, alarm}, 32'h0);
        check("rst_terr", {31'd0, timeout_err}, 32'h0);
        check("rst_in_shdn", {31'd0, in_shdn}, 32'h0);
        rst_n = 1'b1;

        // Periodic reads
        poll_en = 1'b1;
        wait_rise(0, 200, "t1_upd1", c1);
        wait_rise(0, 200, "t1_upd2", c2);
        check("t1_period", c2 - c1, 32'd100);
        wait_rise(1, 100, "t1_vld", v);
        check("t1_sample", {16'd0, sample}, 32'h4190);
        check("t1_alarm", {29'd0, alarm}, 32'h2);

        // Boundary write contends with a pending read
        poll_en = 1'b0;
        bnd_req = 1'b1;
        bnd_sel = 2'b10;
        bnd_val = 11'h155;
        pulse_rd();
        check("t1_vld_pulse", {31'd0, sample_vld}, 32'h0);
        wait_rise(8, 50, "t2_grant", g);
        check("t2_no_upd", {31'd0, sif.s_update}, 32'h0);
        check("t2_twrite", {30'd0, sif.s_twrite}, 32'h2);
        check("t2_tin", {21'd0, sif.s_tin}, 32'h155);
        bnd_val = 11'h7FF;
        bnd_sel = 2'b01;
        wait_rise(7, 20, "t2_busy", v);
        repeat (10) @(negedge clk);
        check("t2_twrite_held", {30'd0, sif.s_twrite}, 32'h2);
        check("t2_tin_held", {21'd0, sif.s_tin}, 32'h155);
        wait_rise(2, 100, "t2_ack", a);
        check("t2_twrite_clr", {30'd0, sif.s_twrite}, 32'h0);
        bnd_req     = 1'b0;
        sif.s_tval  = 12'h0A5;
        sif.s_tcomp = 3'b100;
        wait_rise(0, 50, "t2_rd", u);
        check("t2_guard_gap", u - a, 32'd9);
        wait_rise(1, 100, "t2_vld", v);
        check("t2_sample", {16'd0, sample}, 32'h80A5);
        check("t2_alarm", {29'd0, alarm}, 32'h6);
        alarm_clr = 1'b1;
        @(negedge clk);
        alarm_clr = 1'b0;
        check("t2_alarm_clr", {29'd0, alarm}, 32'h0);

        // Resolution change issues exactly once
        t0 = trig;
        res_cfg = 2'b01;
        wait_rise(6, 100, "t3_res", v);
        repeat (300) @(negedge clk);
        check("t3_res_once", trig - t0, 32'd1);

        // Illegal boundary select is ignored
        t0 = trig;
        a0 = ack_cnt;
        bnd_req = 1'b1;
        bnd_sel = 2'b00;
        bnd_val = 11'h001;
        repeat (60) @(negedge clk);
        check("t3b_sel00_txn", trig - t0, 32'd0);
        check("t3b_sel00_ack", ack_cnt - a0, 32'd0);
        bnd_req = 1'b0;

        // Shutdown suppresses polls
        sd_cfg = 1'b1;
        wait_rise(4, 150, "t4_in_shdn", v);
        check("t4_s_shdn", {31'd0, sif.s_shdn}, 32'h1);
        t0 = trig;
        u0 = upd_cnt;
        pulse_rd();
        poll_en = 1'b1;
        repeat (250) @(negedge clk);
        check("t4_no_txn", trig - t0, 32'd0);
        check("t4_no_upd", upd_cnt - u0, 32'd0);
        poll_en = 1'b0;
        sif.s_tval  = 12'h7FF;
        sif.s_tsign = 1'b1;
        sif.s_tcomp = 3'b000;
        sd_cfg = 1'b0;
        wait_rise(5, 150, "t4_wake", v);
        check("t4_s_shdn_off", {31'd0, sif.s_shdn}, 32'h0);
        wait_rise(1, 150, "t4_resume", v);
        check("t4_sample", {16'd0, sample}, 32'h17FF);
        check("t4_alarm", {29'd0, alarm}, 32'h0);

        // Start timeout
        stuck = 1'b1;
        pulse_rd();
        wait_rise(0, 50, "t5_issue", g);
        wait_rise(3, 100, "t5_terr", t);
        check("t5_to_len", t - g, 32'd32);
        check("t5_upd_drop", {31'd0, sif.s_update}, 32'h0);
        stuck = 1'b0;
        pulse_rd();
        wait_rise(1, 200, "t5_recover", v);
        check("t5_sample", {16'd0, sample}, 32'h17FF);
        check("t5_terr_sticky", {31'd0, timeout_err}, 32'h1);

        // Reset during a busy boundary write
        bnd_req = 1'b1;
        bnd_sel = 2'b11;
        bnd_val = 11'h3FF;
        wait_rise(7, 50, "t6_busy", v);
        repeat (5) @(negedge clk);
        check("t6_twrite", {30'd0, sif.s_twrite}, 32'h3);
        a0 = ack_cnt;
        rst_n = 1'b0;
        #1;
        check("t6_twrite_rst", {30'd0, sif.s_twrite}, 32'h0);
        check("t6_tin_rst", {21'd0, sif.s_tin}, 32'h0);
        check("t6_sample_rst", {16'd0, sample}, 32'h0);
        check("t6_res_rst", {30'd0, sif.s_res}, 32'h3);
        check("t6_terr_rst", {31'd0, timeout_err}, 32'h0);
        check("t6_ack_rst", {31'd0, bnd_ack}, 32'h0);
        bnd_req = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_no_ack", ack_cnt - a0, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mcp9808_scheduler.md
Name: mcp9808_scheduler

Overview:
- Sequences the MCP9808 interface block: issues periodic temperature reads, boundary-register writes, resolution changes and shutdown requests.
- Arbitrates among these requesters with fixed priority and drives the interface's level-style command inputs.
- Captures each completed reading into a sample register.
- Sits between the host-side register bank and the sensor interface; one transaction is outstanding at a time.

Parameters:
- POLL_DIV, 24'd10_000_000: clk cycles between periodic read requests; must be ≥2.
- START_TO, 16'd4096: max cycles to wait for sensor ready to fall after issue.
- DONE_TO, 20'd500_000: max cycles to wait for ready to return once busy.
- GUARD, 4'd8: consecutive cycles ready must be high before the next issue.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- poll_en  in  1  enable periodic reads
- rd_now  in  1  one-cycle pulse: request an immediate read
- bnd_req  in  1  host boundary write request; held until bnd_ack
- bnd_sel  in  2  11=crit, 10=upper, 01=lower; 00 is illegal and ignored
- bnd_val  in  11  boundary value; sampled at grant
- bnd_ack  out  1  one-cycle pulse when the boundary write completes or aborts
- res_cfg  in  2  desired resolution, level
- sd_cfg  in  1  desired shutdown state, level
- s_ready  in  1  sensor ready
- s_tval  in  12  sensor tempVal
- s_tsign  in  1  sensor tempSign
- s_tcomp  in  3  sensor tempComp
- s_update  out  1  sensor update
- s_twrite  out  2  sensor tempWrite
- s_tin  out  11  sensor tempInput
- s_res  out  2  sensor res_i
- s_shdn  out  1  sensor shutdown
- sample  out  16  {tcomp, tsign, tval} of the last completed read
- sample_vld  out  1  one-cycle pulse when sample updates
- alarm  out  3  sticky OR of tcomp over reads; cleared by alarm_clr
- alarm_clr  in  1  clears alarm; a same-cycle set wins
- timeout_err  out  1  sticky; cleared only by reset
- in_shdn  out  1  sensor is in shutdown

Behaviour:
- Reset values:
  - s_res = 2'b11; every other output = 0.
  - All counters = 0; state = GUARD.
- Poll timer:
  - Counts while poll_en is high; on reaching POLL_DIV-1, wraps to 0 and sets poll_pend.
  - rd_now also sets poll_pend.
  - Multiple pending polls coalesce into one. poll_pend clears at grant.
  - When poll_en is low, the counter holds at 0.
- Grant priority, from IDLE only:
  - shutdown change (sd_cfg != s_shdn)
  - boundary write (bnd_req & bnd_sel != 0)
  - resolution change (res_cfg != s_res)
  - poll_pend, suppressed while in_shdn
- States:
  - IDLE: waits for a request; s_ready must be high to grant.
  - ISSUE: drives the command.
    - shutdown: s_shdn <= sd_cfg
    - bound: s_twrite <= bnd_sel, s_tin <= bnd_val
    - resolution: s_res <= res_cfg
    - read: s_update <= 1
    - Exits to BUSY when s_ready falls. If START_TO expires first: timeout_err <= 1, drop the command, bnd_ack if it was a bound write, go to GUARD.
  - BUSY: s_twrite and s_update stay held until s_ready rises.
    - In the cycle s_ready rises: s_update <= 0, s_twrite <= 0.
    - For a read: sample <= {s_tcomp, s_tsign, s_tval}, sample_vld = 1 (one cycle later), alarm |= s_tcomp.
    - For a bound write: bnd_ack pulses.
    - For shutdown: in_shdn <= s_shdn.
    - Go to GUARD.
    - If DONE_TO expires: timeout_err <= 1, drop the command, go to GUARD.
  - GUARD: counts consecutive s_ready-high cycles. Any low cycle restarts the count, which absorbs the sensor's follow-up pointer write. When the count reaches GUARD, go to IDLE.
- s_res and s_shdn are registered levels that change only in ISSUE. They are never driven from the inputs combinationally.
- Boundary handshake:
  - bnd_val and bnd_sel are registered at grant.
  - Changes to them before bnd_ack are ignored.
  - bnd_req must be low for at least one cycle after bnd_ack before the next request.
- Reset asserted mid-transaction:
  - Returns to reset values immediately.
  - No bnd_ack is issued; the host must re-request.
- Width rules:
  - Timers are unsigned and saturate at their limit.
  - The guard counter is 4 bits.

Decomposition:
- Package mcp9808_pkg holds:
  - state encoding (IDLE, ISSUE, BUSY, GUARD)
  - request-kind encoding (REQ_SD, REQ_BND, REQ_RES, REQ_RD)
  - bnd_sel codes, matching the interface's crit/upper/lower/none values
- Sub-module: mcp9808_poll_timer (counter, wrap, coalesced pending flag).

Test Plan:
- POLL_DIV=100, poll_en=1, sensor model with ready low for 40 cycles, tcomp=3'b010, tval=12'h190 → s_update every 100 cycles; sample=16'h4190 with sample_vld pulse; alarm=3'b010.
- bnd_req with sel=2'b10, val=11'h155, plus a poll due in the same cycle → bound write granted first; s_twrite=10 held through BUSY and cleared when ready rises; bnd_ack pulse; the read follows after the GUARD window.
- res_cfg=2'b01 → s_res=01 in ISSUE, one transaction; no repeat while res_cfg stays 01.
- sd_cfg=1 → s_shdn=1, in_shdn=1; polls suppressed while shut down; sd_cfg=0 → s_shdn=0, in_shdn=0, polls resume.
- Sensor never drops ready after issue → timeout_err=1 after START_TO cycles; command cleared; a later grant still proceeds.
- rst low during BUSY → all outputs at reset values next edge, no bnd_ack; sample=0.
